// File: rtl/hsv_convert_arbiter_pkg.sv
// Shared widths, defaults and requester encodings for the two-port HSV converter arbiter.
package hsv_convert_arbiter_pkg;

  localparam int PIX_W              = 24;
  localparam int ID_W               = 1;
  localparam int LAT_DEFAULT        = 18;
  localparam int FIFO_DEPTH_DEFAULT = 32;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  localparam req_id_e RR_RESET = REQ0;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/hsv_convert_arbiter_if.sv
// Requester, converter and result handshakes of the arbiter, bundled with master/slave views.
interface hsv_convert_arbiter_if;
  import hsv_convert_arbiter_pkg::*;

  logic             req0_valid;
  logic [PIX_W-1:0] req0_hsv;
  logic             req0_ready;
  logic             req1_valid;
  logic [PIX_W-1:0] req1_hsv;
  logic             req1_ready;
  logic [PIX_W-1:0] cv_hsv;
  logic [PIX_W-1:0] cv_rgb;
  logic             out_valid;
  logic [PIX_W-1:0] out_rgb;
  logic             out_id;
  logic             out_ready;
  logic             busy;

  modport master (
    output req0_valid, req0_hsv, req1_valid, req1_hsv, cv_rgb, out_ready,
    input  req0_ready, req1_ready, cv_hsv, out_valid, out_rgb, out_id, busy
  );

  modport slave (
    input  req0_valid, req0_hsv, req1_valid, req1_hsv, cv_rgb, out_ready,
    output req0_ready, req1_ready, cv_hsv, out_valid, out_rgb, out_id, busy
  );

endinterface

// File: rtl/hsv_convert_arbiter_chk.sv
// Invariant checks for the arbiter: the credit scheme must never let a result reach a full FIFO.
module hsv_convert_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/hsv_convert_arbiter_conv_result_fifo.sv
// Synchronous first-word-visible FIFO holding converter results; DEPTH must be a power of two.
module conv_result_fifo
  import hsv_convert_arbiter_pkg::*;
#(
  parameter int WIDTH = PIX_W + ID_W,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty    = (count_r == {CNT_W{1'b0}});
  assign full     = (count_r == CNT_W'(DEPTH));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];
  // A push at full is only taken together with a pop, which frees the head slot this edge.
  assign wr_en_s  = push && (!full || pop);
  assign rd_en_s  = pop && !empty;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hsv_convert_arbiter.sv
// Round-robin sharing of one fixed-latency HSV->RGB converter between two requesters, with credit-protected result return.
module hsv_convert_arbiter
  import hsv_convert_arbiter_pkg::*;
#(
  parameter int LAT        = LAT_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  hsv_convert_arbiter_if.slave bus
);

  localparam int IFL_W = $clog2(LAT + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(LAT + FIFO_DEPTH + 1);
  localparam int ENT_W = PIX_W + ID_W;
  localparam logic [IFL_W-1:0] IFL_ONE = IFL_W'(1'b1);

  logic [LAT-1:0]   tag_vld_r;
  logic [LAT-1:0]   tag_id_r;
  logic [IFL_W-1:0] inflight_r;
  logic [PIX_W-1:0] cv_hsv_r;
  req_id_e          rr_r;

  req_id_e          grant_s;
  logic [OCC_W-1:0] occ_s;
  logic             can_issue_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;
  logic [PIX_W-1:0] issue_hsv_s;
  logic             push_s;
  logic             pop_s;
  logic [ENT_W-1:0] push_data_s;
  logic [ENT_W-1:0] pop_data_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // Credits count everything already committed: in the converter or waiting in the FIFO.
  assign occ_s       = OCC_W'(inflight_r) + OCC_W'(fifo_count_s);
  assign can_issue_s = (occ_s < OCC_W'(FIFO_DEPTH));

  // Grant selection: a lone requester wins, a tie goes to the round-robin favourite.
  always_comb begin
    grant_s = rr_r;
    case ({bus.req1_valid, bus.req0_valid})
      2'b01:   grant_s = REQ0;
      2'b10:   grant_s = REQ1;
      2'b11:   grant_s = rr_r;
      default: grant_s = rr_r;
    endcase
  end

  // Ready generation, held low during reset and whenever credits are exhausted.
  always_comb begin
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (reset) begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end else begin
      ready0_s = can_issue_s && (grant_s == REQ0);
      ready1_s = can_issue_s && (grant_s == REQ1);
    end
  end

  assign accept_s    = (ready0_s && bus.req0_valid) || (ready1_s && bus.req1_valid);
  assign issue_hsv_s = (grant_s == REQ1) ? bus.req1_hsv : bus.req0_hsv;

  // Issue register, rr pointer, tag shift register and in-flight counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cv_hsv_r   <= {PIX_W{1'b0}};
      rr_r       <= RR_RESET;
      tag_vld_r  <= {LAT{1'b0}};
      tag_id_r   <= {LAT{1'b0}};
      inflight_r <= {IFL_W{1'b0}};
    end else begin
      tag_vld_r <= {tag_vld_r[LAT-2:0], accept_s};
      tag_id_r  <= {tag_id_r[LAT-2:0], accept_s && (grant_s == REQ1)};
      if (accept_s) begin
        cv_hsv_r <= issue_hsv_s;
        rr_r     <= other_req(grant_s);
      end
      case ({accept_s, push_s})
        2'b10:   inflight_r <= inflight_r + IFL_ONE;
        2'b01:   inflight_r <= inflight_r - IFL_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // The converter output lines up with the tag that leaves the last stage.
  assign push_s      = tag_vld_r[LAT-1];
  assign push_data_s = {bus.cv_rgb, tag_id_r[LAT-1]};
  assign pop_s       = !fifo_empty_s && bus.out_ready;

  conv_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  hsv_convert_arbiter_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .full  (fifo_full_s)
  );

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.cv_hsv     = cv_hsv_r;
  assign bus.out_valid  = !fifo_empty_s;
  assign bus.out_rgb    = pop_data_s[ENT_W-1:ID_W];
  assign bus.out_id     = pop_data_s[0];
  assign bus.busy       = (inflight_r != {IFL_W{1'b0}}) || !fifo_empty_s;

endmodule

// File: tb/tb_hsv_convert_arbiter.sv
// Randomised scoreboard bench: converter modelled as a LAT-cycle XOR delay, results checked in issue order.
module tb_hsv_convert_arbiter;

  localparam int LAT   = 18;
  localparam int DEPTH = 32;
  localparam logic [23:0] XMASK = 24'h5A5A5A;

  typedef struct {
    logic [23:0] rgb;
    logic        id;
    int          acc_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cnt0 = 0;
  int   acc_cnt1 = 0;

  exp_t        exp_q[$];
  exp_t        item;
  logic        pref = 1'b0;
  logic        exp_can;
  logic        cv_pending = 1'b0;
  logic [23:0] cv_exp;
  logic [23:0] conv_pipe [LAT-1];

  hsv_convert_arbiter_if bus();

  hsv_convert_arbiter #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural converter: cv_rgb at edge t+LAT reflects cv_hsv written at edge t.
  always @(posedge clk) begin
    conv_pipe[0] <= bus.cv_hsv ^ XMASK;
    for (int i = 1; i < LAT - 1; i++) conv_pipe[i] <= conv_pipe[i-1];
  end
  assign bus.cv_rgb = conv_pipe[LAT-2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h at cycle %0d", name, got, req, cyc);
    end
  endtask

  // Monitor and scoreboard: everything is judged at the negedge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pref       = 1'b0;
      cv_pending = 1'b0;
      check("ready_in_reset", {bus.req1_ready, bus.req0_ready}, 0);
    end else begin
      if (cv_pending) begin
        check("cv_hsv_issue", bus.cv_hsv, cv_exp);
        cv_pending = 1'b0;
      end
      check("out_valid", bus.out_valid,
            (exp_q.size() != 0) && (cyc - exp_q[0].acc_cyc >= LAT + 1));
      check("busy", bus.busy, exp_q.size() != 0);
      exp_can = (exp_q.size() < DEPTH);
      if (bus.req0_valid && bus.req1_valid) begin
        check("double_ready", bus.req0_ready & bus.req1_ready, 0);
        if (pref == 1'b0) check("ready0_tie", bus.req0_ready, exp_can);
        else              check("ready1_tie", bus.req1_ready, exp_can);
      end else if (bus.req0_valid) begin
        check("ready0", bus.req0_ready, exp_can);
      end else if (bus.req1_valid) begin
        check("ready1", bus.req1_ready, exp_can);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out got rgb=%h id=%0d required none", bus.out_rgb, bus.out_id);
        end else begin
          item = exp_q.pop_front();
          check("out_rgb", bus.out_rgb, item.rgb);
          check("out_id", bus.out_id, item.id);
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        exp_q.push_back('{rgb: bus.req0_hsv ^ XMASK, id: 1'b0, acc_cyc: cyc});
        cv_exp = bus.req0_hsv; cv_pending = 1'b1; pref = 1'b1; acc_cnt0++;
      end else if (bus.req1_valid && bus.req1_ready) begin
        exp_q.push_back('{rgb: bus.req1_hsv ^ XMASK, id: 1'b1, acc_cyc: cyc});
        cv_exp = bus.req1_hsv; cv_pending = 1'b1; pref = 1'b0; acc_cnt1++;
      end
      check("occ_bound", exp_q.size() <= DEPTH, 1);
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one pixel until accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input logic id, input logic [23:0] hsv);
    int n = 0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_hsv = hsv; end
    else    begin bus.req0_valid = 1'b1; bus.req0_hsv = hsv; end
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? bus.req1_ready : bus.req0_ready) && n < 200);
    check("send_accepted", n < 200, 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic stream(input logic en0, input logic en1, input int cycles, input logic toggle);
    for (int i = 0; i < cycles; i++) begin
      bus.req0_valid = en0;
      bus.req1_valid = en1;
      bus.req0_hsv   = 24'($urandom);
      bus.req1_hsv   = 24'($urandom);
      if (toggle) bus.out_ready = ~bus.out_ready;
      @(posedge clk);
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    bus.out_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.busy) && n < maxc);
    check("drain_busy", bus.busy, 0);
    check("drain_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_hsv   = 24'h000000;
    bus.req1_hsv   = 24'h000000;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_cv_hsv", bus.cv_hsv, 0);
    check("reset_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Single requester, back-to-back.
    send(1'b0, 24'h00FFFF);
    bus.req0_valid = 1'b1;
    send(1'b0, 24'h2AFF80);
    send(1'b0, 24'h55FF40);
    send(1'b0, 24'h80FFFF);
    drain(100);

    // Both requesters valid continuously from reset: strict alternation.
    apply_reset();
    acc_cnt0 = 0;
    acc_cnt1 = 0;
    for (int i = 0; i < 400 && (acc_cnt0 + acc_cnt1) < 100; i++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_hsv   = 24'($urandom);
      bus.req1_hsv   = 24'($urandom);
      @(posedge clk);
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr_count0", acc_cnt0, 50);
    check("rr_count1", acc_cnt1, 50);
    drain(100);

    // Backpressure: credits stop issue at exactly FIFO_DEPTH.
    bus.out_ready = 1'b0;
    acc_cnt0 = 0;
    stream(1'b1, 1'b0, 60, 1'b0);
    check("bp_accepts", acc_cnt0, DEPTH);
    bus.out_ready = 1'b1;
    stream(1'b1, 1'b0, 40, 1'b0);

    // Hold full while the consumer toggles, with random two-requester traffic.
    bus.out_ready = 1'b0;
    stream(1'b1, 1'b1, 30, 1'b0);
    stream(1'b1, 1'b1, 100, 1'b1);
    drain(200);

    // Reset with 5 buffered and 10 in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'(i % 2), 24'($urandom));
    repeat (LAT + 3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      bus.req0_valid = 1'b1;
      send(1'b0, 24'($urandom));
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_reset_cv_hsv", bus.cv_hsv, 0);
    check("post_reset_valid", bus.out_valid, 0);
    check("post_reset_busy", bus.busy, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_reset_idle", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // S=0 and H wrap corner values.
    send(1'b0, 24'hFF0080);
    send(1'b1, 24'h000000);
    send(1'b1, 24'hFF0080);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsv_convert_arbiter.md
Name: hsv_convert_arbiter

Overview:
Shares one pipelined HSV-to-RGB converter between two pixel requesters (camera colour-reduction path, palette path).
- Round-robin arbitration; each accepted pixel is issued to the converter.
- Issued pixels are tracked through the converter's fixed latency with an ID tag.
- Results are buffered in a credit-protected return FIFO, so the converter never needs to stall and no result is ever dropped under output backpressure.

Parameters:
LAT, 18, converter latency in cycles from cv_hsv register update to valid cv_rgb (divider latency + output register)
FIFO_DEPTH, 32, return FIFO entries; power of two, >= 2
PIX_W, 24, pixel width (HSV and RGB)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 pixel valid
req0_hsv  in  24  requester 0 pixel {H,S,V}
req0_ready  out  1  requester 0 pixel accepted this cycle when high with req0_valid
req1_valid  in  1  requester 1 pixel valid
req1_hsv  in  24  requester 1 pixel {H,S,V}
req1_ready  out  1  requester 1 accept
cv_hsv  out  24  registered input to converter
cv_rgb  in  24  converter output, passed through unmodified (bit order as produced by converter)
out_valid  out  1  result available
out_rgb  out  24  result pixel
out_id  out  1  requester that issued this pixel
out_ready  in  1  consumer accepts result when high with out_valid
busy  out  1  high while any pixel in flight or FIFO non-empty

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high, sampled on posedge clk.
- Reset values:
  - cv_hsv=0, out_valid=0, busy=0, in-flight tag pipe cleared, FIFO pointers/count=0, rr pointer=0 (requester 0 preferred next).
  - req*_ready=0 while reset high.
- Credits:
  - occ = in_flight_count + fifo_count.
  - can_issue = (occ < FIFO_DEPTH), where occ is computed from registered state; a pop in the same cycle does not add credit until the next cycle.
- Arbitration (combinational grant, registered rr pointer):
  - If can_issue and only one valid, grant it.
  - If both valid, grant the rr-preferred one.
  - reqN_ready = can_issue & grant==N. ready never asserted without can_issue.
- Issue:
  - On accept at edge t, cv_hsv <= granted hsv.
  - A tag {1'b1,id} enters the LAT-deep valid/ID shift register.
  - rr pointer <= other requester.
  - With no accept, cv_hsv holds and a zero tag enters.
- Capture: when a tag's valid bit emerges from the shift register, {cv_rgb,id} is pushed into the FIFO that same edge. The result is sampled exactly LAT cycles after cv_hsv updated.
- Latency: accept at edge t -> result pushed at edge t+LAT -> out_valid high in the cycle after edge t+LAT (FIFO is registered, first-word-visible).
- Output:
  - out_valid = fifo non-empty; out_rgb/out_id show the FIFO head.
  - Pop on out_valid & out_ready.
  - Results are in issue order across both requesters.
- Boundary conditions:
  - Simultaneous push and pop is legal at any count, including full (count unchanged).
  - The credit scheme guarantees push never occurs while full. Assertion: push & full never true.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - A requester whose valid drops before ready loses nothing; the arbiter holds no state for it.
  - rr pointer advances only on accept.
  - Reset mid-operation discards all in-flight and buffered pixels. No out_valid in the cycle after the reset edge.
  - The converter's pipeline contents after reset are ignored because tags are cleared.
- busy = (in_flight_count != 0) | (fifo_count != 0).

Decomposition:
- Shared package/include: PIX_W, ID width (1), reset/priority encodings, default LAT matching the converter build.
- One sub-module: conv_result_fifo. Synchronous FIFO, width PIX_W+1, depth FIFO_DEPTH, with count, full and empty outputs.
- Arbiter, tag shift register and credit counter stay in the top.

Test Plan:
Bench uses a behavioural converter model with fixed LAT=18 (output = input XOR 24'h5A5A5A, delayed).
- Single requester: req0 sends 0x00FFFF,0x2AFF80,0x55FF40,0x80FFFF back-to-back, out_ready=1 -> four results, id 0, in order, first out_valid 19 cycles after first accept, then one per cycle.
- Both valid continuously from reset -> accepts alternate 0,1,0,1 starting with req0; out_id sequence 0,1,0,1; no requester starved over 100 pixels.
- Backpressure: out_ready=0, req0 streaming -> exactly 32 accepts, then req0_ready low. Raising out_ready yields 32 results with no loss or duplication; issuing resumes one cycle after first pop.
- Full with simultaneous push/pop: hold occ at 32 with out_ready toggling every cycle -> count never exceeds 32, no assertion fires, output order preserved.
- Reset mid-stream: assert reset for 1 cycle with 10 in flight and 5 buffered -> next cycle out_valid=0, busy=0, cv_hsv=0; no stale result emitted during the following 40 cycles.
- S=0 and H wrap values: 0xFF0080 and 0x000000 pass through -> out_rgb equals the model output exactly; id correct.
